jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Programmable modulo-MOD up/down counter. Its state register is a bank of WIDTH JK-type bits.
- The block is the driving side of the JK interface. It computes the target next state, then inverts the JK characteristic (excitation) to produce per-bit J/K commands.
- Used as the sequence/BCD counter for the digital-circuits problem set. J/K monitor outputs let a bench check excitation correctness directly.

Parameters:
- WIDTH, 4, state bits.
- MOD, 10, count modulus. Legal range 2 <= MOD <= 2**WIDTH. Elaboration-time assertion otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up_dn  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  counter state.
- q_n  out  WIDTH  bitwise complement of q, always ~q.
- j_mon  out  WIDTH  J command applied at the coming edge (combinational).
- k_mon  out  WIDTH  K command applied at the coming edge (combinational).
- tc  out  1  terminal-count pulse, registered.
- load_err  out  1  illegal-load pulse, registered.

Behaviour:
- Reset: clk and rst are as already decided (reset rst, asynchronous, active-high; clock clk).
  - While rst=1: q=0, q_n=all ones, tc=0, load_err=0, immediately, independent of clk.
  - Reset asserted mid-count aborts the count. First count after release starts from 0.
- Target next state d, priority order:
  - load=1: d = load_val if load_val < MOD, else d = 0.
  - else en=1, up_dn=1: d = (q == MOD-1) ? 0 : q+1.
  - else en=1, up_dn=0: d = (q == 0) ? MOD-1 : q-1.
  - else: d = q.
- Excitation, fixed don't-care choice, per bit i:
  - j[i] = ~q[i] & d[i]
  - k[i] = q[i] & ~d[i]
  - Consequences: hold = 00, set = 10, reset = 01. Toggle (11) is never issued.
  - j and k are never both 1. The bench asserts this every cycle.
- State update per bit at posedge clk:
  - 00 hold, 01 -> 0, 10 -> 1, 11 -> ~q.
  - The register implements full JK semantics even though 11 is unused.
- Latency: one clock from en/load to new q. j_mon and k_mon reflect the current inputs combinationally.
- tc: high for exactly the one cycle following an edge where an enabled count wrapped.
  - Up wrap: MOD-1 -> 0.
  - Down wrap: 0 -> MOD-1.
  - A load never raises tc, even if it loads 0 or MOD-1.
- load_err: high for one cycle following a load edge with load_val >= MOD. That load puts 0 into q.
- Simultaneous events:
  - load and en both high: load wins, no count, no tc.
  - en=0 with load=0: hold, tc=0.
- State q >= MOD can only arise from a fault. If it occurs, the next enabled up-count goes to 0 (treated as a wrap, tc=1). A down-count goes to q-1.

Decomposition:
- Shared package jk_pkg contains:
  - typedef enum logic [1:0] jk_cmd_e: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - function jk_next(q, cmd) implementing the characteristic equation.
  - function jk_excite(q, d) returning jk_cmd_e per the rule above.
- Natural sub-module: jk_excitation. Per-bit combinational map (q, d) -> (j, k), instantiated WIDTH times via generate.
- The top level holds the next-state selection, the JK register bank, and the tc/load_err registers.

Test Plan (WIDTH=4, MOD=10):
- Reset, then hold en=1, up_dn=1 for 12 clocks -> q = 1..9, 0, 1, 2. tc=1 only in the cycle after q becomes 0. q_n = ~q throughout.
- load=1, load_val=3, then en=1, up_dn=0 for 5 clocks -> q = 3, 2, 1, 0, 9, 8. tc=1 in the cycle after q becomes 9.
- load=1, load_val=12 -> q=0, load_err=1 for one cycle, tc=0. With load=1, load_val=9, en=1 -> q=9, no count, load_err=0.
- With q=5 (0101) and target 6 (0110) -> j_mon=0010, k_mon=0001. Across a random 1000-cycle run, (j_mon & k_mon) is always 0.
- Assert rst asynchronously mid-cycle at q=7 -> q=0 before the next clk edge, tc=0, load_err=0. After release, count resumes 1, 2.
- en=0, load=0 for 4 clocks at q=4 -> q stays 4, j_mon=k_mon=0, tc=0.

Source files
------------

// File: rtl/jk_pkg.sv
// JK flip-flop helpers: command encoding, characteristic equation and the
// fixed excitation map used by the counter (never issues toggle).
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    function automatic logic jk_next(input logic q, input jk_cmd_e cmd);
        case (cmd)
            JK_HOLD: return q;
            JK_RST:  return 1'b0;
            JK_SET:  return 1'b1;
            default: return ~q;
        endcase
    endfunction

    function automatic jk_cmd_e jk_excite(input logic q, input logic d);
        if (~q & d) return JK_SET;
        if (q & ~d) return JK_RST;
        return JK_HOLD;
    endfunction

endpackage

// File: rtl/jk_excitation.sv
// Single-bit excitation: drives J/K so that a JK bit at q moves to d.
module jk_excitation
    import jk_pkg::*;
(
    input  logic q,
    input  logic d,
    output logic j,
    output logic k
);

    jk_cmd_e cmd;

    assign cmd = jk_excite(q, d);
    assign j   = cmd[1];
    assign k   = cmd[0];

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built on a bank of JK bits; next state is
// chosen first, then translated into per-bit J/K commands.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] j_mon,
    output logic [WIDTH-1:0] k_mon,
    output logic             tc,
    output logic             load_err
);

    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("jk_mod_counter: MOD must lie in 2 .. 2**WIDTH");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] d;
    logic             wrap;
    logic             load_ok;

    assign load_ok = {1'b0, load_val} < MOD_EXT;

    // q >= MOD only happens after a fault; an up-count then falls back to 0 as a wrap.
    always_comb begin
        d    = q;
        wrap = 1'b0;
        if (load) begin
            d = load_ok ? load_val : '0;
        end else if (en) begin
            if (up_dn) begin
                if (q >= TOP) begin
                    d    = '0;
                    wrap = 1'b1;
                end else begin
                    d = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    d    = TOP;
                    wrap = 1'b1;
                end else begin
                    d = q - WIDTH'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_exc
        jk_excitation u_exc (
            .q (q[i]),
            .d (d[i]),
            .j (j_mon[i]),
            .k (k_mon[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                q[i] <= jk_next(q[i], jk_cmd_e'({j_mon[i], k_mon[i]}));
            end
            tc       <= wrap;
            load_err <= load & ~load_ok;
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MOD=10) with directed vectors.
module tb_jk_mod_counter;

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q, q_n, j_mon, k_mon;
    logic       tc, load_err;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .q_n      (q_n),
        .j_mon    (j_mon),
        .k_mon    (k_mon),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clocked vector: inputs applied at negedge, expected post-edge state queued.
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] v,
                        input logic [3:0] eq, input logic etc, input logic eerr);
        exp_t x;
        @(negedge clk);
        en = e; up_dn = u; load = l; load_val = v;
        x.q = eq; x.tc = etc; x.err = eerr;
        sb.push_back(x);
    endtask

    // Monitor: one queued expectation is retired per clock edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", q, x.q);
                chk("q_n", q_n, ~x.q);
                chk("tc", {3'b0, tc}, {3'b0, x.tc});
                chk("load_err", {3'b0, load_err}, {3'b0, x.err});
            end
        end
    end

    // J and K must never be asserted together on the same bit.
    always @(negedge clk) begin
        #2;
        if (!rst) chk("j_and_k", j_mon & k_mon, 4'h0);
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, 4'h0);
        chk("rst_q_n", q_n, 4'hF);
        chk("rst_tc", {3'b0, tc}, 4'h0);
        chk("rst_err", {3'b0, load_err}, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Up count through the wrap
        for (int i = 1; i <= 12; i++)
            step(1, 1, 0, 4'h0, 4'(i % 10), (i == 10), 0);

        // Load 3, count down through the wrap
        step(0, 0, 1, 4'h3, 4'h3, 0, 0);
        step(1, 0, 0, 4'h0, 4'h2, 0, 0);
        step(1, 0, 0, 4'h0, 4'h1, 0, 0);
        step(1, 0, 0, 4'h0, 4'h0, 0, 0);
        step(1, 0, 0, 4'h0, 4'h9, 1, 0);
        step(1, 0, 0, 4'h0, 4'h8, 0, 0);

        // Illegal load, then load beats enable
        step(0, 0, 1, 4'hC, 4'h0, 0, 1);
        step(1, 1, 1, 4'h9, 4'h9, 0, 0);
        step(0, 0, 0, 4'h0, 4'h9, 0, 0);

        // Loading 0 never raises tc; next down-count wraps
        step(0, 0, 1, 4'h0, 4'h0, 0, 0);
        step(1, 0, 0, 4'h0, 4'h9, 1, 0);

        // Excitation for 5 -> 6
        step(0, 0, 1, 4'h5, 4'h5, 0, 0);
        step(1, 1, 0, 4'h0, 4'h6, 0, 0);
        #1;
        chk("j_5to6", j_mon, 4'b0010);
        chk("k_5to6", k_mon, 4'b0001);

        // Hold at 4
        step(0, 0, 1, 4'h4, 4'h4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, i[0], 0, 4'h0, 4'h4, 0, 0);
            #1;
            chk("hold_j", j_mon, 4'h0);
            chk("hold_k", k_mon, 4'h0);
        end

        // Asynchronous reset mid-cycle at q=7
        step(0, 0, 1, 4'h7, 4'h7, 0, 0);
        @(posedge clk);
        #2;
        en = 1'b0; load = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_q", q, 4'h0);
        chk("arst_q_n", q_n, 4'hF);
        chk("arst_tc", {3'b0, tc}, 4'h0);
        chk("arst_err", {3'b0, load_err}, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0, 4'h0, 4'h1, 0, 0);
        step(1, 1, 0, 4'h0, 4'h2, 0, 0);

        // Random run; only the J/K exclusivity monitor is active
        @(posedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            en       = 1'($urandom_range(0, 1));
            up_dn    = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 4'(sb.size()), 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
